// File: rtl/vend_param_pkg.sv
// Shared types and constants for the parametrised vending controller.
// Coin values and the change unit are kept here so other acceptors can reuse them.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } vend_state_e;

    localparam int NICKEL_C    = 5;
    localparam int DIME_C      = 10;
    localparam int QUARTER_C   = 25;
    localparam int CHANGE_UNIT = 5;

endpackage

// File: rtl/vend_param_if.sv
// Coin-acceptor / actuator bundle between the front end and the vending controller.
// master drives coins and cancel; slave is the controller.
interface vend_param_if #(
    parameter int CREDIT_W = 7
);
    logic                Nickel;
    logic                Dime;
    logic                Quarter;
    logic                Cancel;
    logic                Dispense;
    logic                ChangeNickel;
    logic                Reject;
    logic [CREDIT_W-1:0] Credit;
    logic [1:0]          State;

    modport master (
        output Nickel, Dime, Quarter, Cancel,
        input  Dispense, ChangeNickel, Reject, Credit, State
    );

    modport slave (
        input  Nickel, Dime, Quarter, Cancel,
        output Dispense, ChangeNickel, Reject, Credit, State
    );
endinterface

// File: rtl/vend_param_coin_sum.sv
// Combinational coin-pulse to cents adder; simultaneous coins are summed.
// One bit wider than the credit register so credit + sum never overflows.
module vend_coin_sum
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 7
) (
    input  logic                i_nickel,
    input  logic                i_dime,
    input  logic                i_quarter,
    output logic [CREDIT_W:0]   o_sum
);

    always_comb begin
        o_sum = (CREDIT_W+1)'((i_nickel  ? NICKEL_C  : 0) +
                              (i_dime    ? DIME_C    : 0) +
                              (i_quarter ? QUARTER_C : 0));
    end

endmodule

// File: rtl/vend_param.sv
// Vending controller: accumulates coin credit against PRICE, dispenses, then
// pays out the excess as nickel-change pulses. Coins while busy are rejected.
module vend_param
    import vend_pkg::*;
#(
    parameter int PRICE    = 15,
    parameter int CREDIT_W = 7
) (
    input  logic          CLK,
    input  logic          Reset,
    vend_param_if.slave   bus
);

    if (PRICE <= 0 || (PRICE % 5) != 0) begin : g_bad_price
        $fatal(1, "vend_param: PRICE must be a nonzero multiple of 5");
    end
    if (PRICE + 35 >= 2**CREDIT_W) begin : g_bad_width
        $fatal(1, "vend_param: CREDIT_W too small for PRICE");
    end

    localparam logic [CREDIT_W:0]   PRICE_W = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W-1:0] UNIT_W  = CREDIT_W'(CHANGE_UNIT);

    vend_state_e         r_state, w_state_nxt;
    logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
    logic                r_reject, w_reject_nxt;
    logic [CREDIT_W:0]   w_sum;
    logic [CREDIT_W:0]   w_total;
    logic [CREDIT_W:0]   w_after_price;

    vend_coin_sum #(.CREDIT_W(CREDIT_W)) u_coin_sum (
        .i_nickel  (bus.Nickel),
        .i_dime    (bus.Dime),
        .i_quarter (bus.Quarter),
        .o_sum     (w_sum)
    );

    assign w_total       = {1'b0, r_credit} + w_sum;
    assign w_after_price = w_total - PRICE_W;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state  <= IDLE;
            r_credit <= '0;
            r_reject <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_credit <= w_credit_nxt;
            r_reject <= w_reject_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_credit_nxt = r_credit;
        w_reject_nxt = 1'b0;
        case (r_state)
            IDLE, ACCUM: begin
                // Cancel outranks a completing coin: everything inserted is refunded.
                if (bus.Cancel) begin
                    w_credit_nxt = w_total[CREDIT_W-1:0];
                    w_state_nxt  = (w_total != '0) ? CHANGE : IDLE;
                end else if (w_total >= PRICE_W) begin
                    w_credit_nxt = w_after_price[CREDIT_W-1:0];
                    w_state_nxt  = VEND;
                end else if (w_sum != '0) begin
                    w_credit_nxt = w_total[CREDIT_W-1:0];
                    w_state_nxt  = ACCUM;
                end
            end
            VEND: begin
                w_reject_nxt = (w_sum != '0);
                w_state_nxt  = (r_credit != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                w_reject_nxt = (w_sum != '0);
                if (r_credit <= UNIT_W) begin
                    w_credit_nxt = '0;
                    w_state_nxt  = IDLE;
                end else begin
                    w_credit_nxt = r_credit - UNIT_W;
                end
            end
            default: begin
                w_credit_nxt = '0;
                w_state_nxt  = IDLE;
            end
        endcase
    end

    assign bus.Dispense     = (r_state == VEND);
    assign bus.ChangeNickel = (r_state == CHANGE);
    assign bus.Reject       = r_reject;
    assign bus.Credit       = r_credit;
    assign bus.State        = r_state;

endmodule

// File: tb/tb_vend_param.sv
// Self-checking bench for vend_param at PRICE=15, CREDIT_W=7: expected outputs
// for each clock are queued with the stimulus and compared after the edge.
module tb_vend_param;

    typedef struct {
        string      tag;
        logic [1:0] st;
        int         cr;
        logic       disp;
        logic       chg;
        logic       rej;
    } exp_t;

    logic CLK;
    logic Reset;
    int   n_checks;
    int   n_errors;
    exp_t exp_q[$];

    vend_param_if #(.CREDIT_W(7)) bus ();

    vend_param #(.PRICE(15), .CREDIT_W(7)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input exp_t e);
        check_val({e.tag, ".state"}, int'(bus.State),        int'(e.st));
        check_val({e.tag, ".credit"}, int'(bus.Credit),      e.cr);
        check_val({e.tag, ".disp"},  int'(bus.Dispense),     int'(e.disp));
        check_val({e.tag, ".chg"},   int'(bus.ChangeNickel), int'(e.chg));
        check_val({e.tag, ".rej"},   int'(bus.Reject),       int'(e.rej));
    endtask

    // Drive one cycle of inputs, queue what the DUT must show after the edge,
    // then pop and compare once the edge has passed.
    task automatic step(input string tag, input logic n, input logic d,
                        input logic q, input logic c, input logic [1:0] st,
                        input int cr, input logic disp, input logic chg,
                        input logic rej);
        exp_t e;
        e.tag = tag; e.st = st; e.cr = cr; e.disp = disp; e.chg = chg; e.rej = rej;
        exp_q.push_back(e);
        bus.Nickel = n; bus.Dime = d; bus.Quarter = q; bus.Cancel = c;
        @(posedge CLK);
        #1;
        bus.Nickel = 1'b0; bus.Dime = 1'b0; bus.Quarter = 1'b0; bus.Cancel = 1'b0;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s.queue: obs=empty exp=entry", tag);
        end else begin
            check_outputs(exp_q.pop_front());
        end
    endtask

    task automatic idle_step(input string tag, input logic [1:0] st, input int cr,
                             input logic disp, input logic chg, input logic rej);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b0, st, cr, disp, chg, rej);
    endtask

    localparam logic [1:0] S_IDLE = 2'd0, S_ACC = 2'd1, S_VEND = 2'd2, S_CHG = 2'd3;

    initial begin
        exp_t r;
        n_checks = 0;
        n_errors = 0;
        bus.Nickel = 1'b0; bus.Dime = 1'b0; bus.Quarter = 1'b0; bus.Cancel = 1'b0;
        Reset = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        r.tag = "reset"; r.st = S_IDLE; r.cr = 0; r.disp = 0; r.chg = 0; r.rej = 0;
        check_outputs(r);
        Reset = 1'b0;

        // Three spaced nickels: exact price, no change.
        step("n3a", 1, 0, 0, 0, S_ACC, 5, 0, 0, 0);
        idle_step("n3b", S_ACC, 5, 0, 0, 0);
        step("n3c", 1, 0, 0, 0, S_ACC, 10, 0, 0, 0);
        idle_step("n3d", S_ACC, 10, 0, 0, 0);
        step("n3e", 1, 0, 0, 0, S_VEND, 0, 1, 0, 0);
        idle_step("n3f", S_IDLE, 0, 0, 0, 0);

        // Dime, dime: 5 c change.
        step("dda", 0, 1, 0, 0, S_ACC, 10, 0, 0, 0);
        step("ddb", 0, 1, 0, 0, S_VEND, 5, 1, 0, 0);
        idle_step("ddc", S_CHG, 5, 0, 1, 0);
        idle_step("ddd", S_IDLE, 0, 0, 0, 0);

        // Dime + quarter together: 20 c change as four pulses.
        step("dqa", 0, 1, 1, 0, S_VEND, 20, 1, 0, 0);
        idle_step("dqb", S_CHG, 20, 0, 1, 0);
        idle_step("dqc", S_CHG, 15, 0, 1, 0);
        idle_step("dqd", S_CHG, 10, 0, 1, 0);
        idle_step("dqe", S_CHG, 5, 0, 1, 0);
        idle_step("dqf", S_IDLE, 0, 0, 0, 0);

        // Quarter, nickel during 2nd change cycle is rejected.
        step("qra", 0, 0, 1, 0, S_VEND, 10, 1, 0, 0);
        idle_step("qrb", S_CHG, 10, 0, 1, 0);
        idle_step("qrc", S_CHG, 5, 0, 1, 0);
        step("qrd", 1, 0, 0, 0, S_IDLE, 0, 0, 0, 1);
        idle_step("qre", S_IDLE, 0, 0, 0, 0);

        // Nickel then cancel refunds; cancel with no credit does nothing.
        step("cna", 1, 0, 0, 0, S_ACC, 5, 0, 0, 0);
        step("cnb", 0, 0, 0, 1, S_CHG, 5, 0, 1, 0);
        idle_step("cnc", S_IDLE, 0, 0, 0, 0);
        step("cnd", 0, 0, 0, 1, S_IDLE, 0, 0, 0, 0);
        idle_step("cne", S_IDLE, 0, 0, 0, 0);

        // Dime + cancel in VEND: coin rejected, cancel ignored, change unaffected.
        step("cva", 0, 0, 1, 0, S_VEND, 10, 1, 0, 0);
        step("cvb", 0, 1, 0, 1, S_CHG, 10, 0, 1, 1);
        idle_step("cvc", S_CHG, 5, 0, 1, 0);
        idle_step("cvd", S_IDLE, 0, 0, 0, 0);

        // Worst case: 10 c credit plus all three coins leaves 35 c change.
        step("wca", 0, 1, 0, 0, S_ACC, 10, 0, 0, 0);
        step("wcb", 1, 1, 1, 0, S_VEND, 35, 1, 0, 0);
        for (int k = 35; k >= 5; k -= 5)
            idle_step($sformatf("wc%0d", k), S_CHG, k, 0, 1, 0);
        idle_step("wcz", S_IDLE, 0, 0, 0, 0);

        // Asynchronous reset mid-change discards owed credit.
        step("rsa", 0, 0, 1, 0, S_VEND, 10, 1, 0, 0);
        idle_step("rsb", S_CHG, 10, 0, 1, 0);
        #2;
        Reset = 1'b1;
        #1;
        r.tag = "rsasync"; r.st = S_IDLE; r.cr = 0; r.disp = 0; r.chg = 0; r.rej = 0;
        check_outputs(r);
        @(posedge CLK);
        #1;
        Reset = 1'b0;
        step("rsc", 0, 1, 0, 0, S_ACC, 10, 0, 0, 0);

        check_val("queue.drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
